// File: rtl/alu_vector_pkg.sv
// Shared types and constants for the ALU vector player.
// Vector field layout, FSM states and ALU function codes.
package alu_vector_pkg;

   localparam int VEC_W     = 112;
   localparam int F_MSB     = 110;
   localparam int F_LSB     = 108;
   localparam int A_MSB     = 107;
   localparam int A_LSB     = 76;
   localparam int B_MSB     = 75;
   localparam int B_LSB     = 44;
   localparam int Y_MSB     = 43;
   localparam int Y_LSB     = 12;
   localparam int ZERO_BIT  = 8;
   localparam int CARRY_BIT = 4;
   localparam int OVF_BIT   = 0;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_WAIT,
      S_APPLY,
      S_SETTLE,
      S_CHECK,
      S_DONE
   } state_t;

endpackage

// File: rtl/alu_vector_player_if.sv
// ROM read bus and ALU drive/sense bus of the vector player.
// master = player side, slave = ROM/ALU side.
interface alu_vector_player_if #(
   parameter int WIDTH  = 32,
   parameter int ADDR_W = 6
);
   import alu_vector_pkg::*;

   logic              vec_rd_en;
   logic [ADDR_W-1:0] vec_addr;
   logic [VEC_W-1:0]  vec_data;
   logic [2:0]        alu_f;
   logic [WIDTH-1:0]  alu_a;
   logic [WIDTH-1:0]  alu_b;
   logic [WIDTH-1:0]  alu_y;
   logic              alu_zero;
   logic              alu_carry;
   logic              alu_overflow;

   modport master (
      output vec_rd_en, vec_addr,
      output alu_f, alu_a, alu_b,
      input  vec_data,
      input  alu_y, alu_zero,
      input  alu_carry, alu_overflow
   );

   modport slave (
      input  vec_rd_en, vec_addr,
      input  alu_f, alu_a, alu_b,
      output vec_data,
      output alu_y, alu_zero,
      output alu_carry, alu_overflow
   );

endinterface

// File: rtl/alu_vector_unpack.sv
// Combinational slicer of a 112-bit test vector.
// Padding bits are dropped.
module alu_vector_unpack
   import alu_vector_pkg::*;
(
   input  logic [VEC_W-1:0] vec,
   output logic [2:0]       f,
   output logic [31:0]      a,
   output logic [31:0]      b,
   output logic [31:0]      exp_y,
   output logic             exp_zero,
   output logic             exp_carry,
   output logic             exp_overflow
);

   logic unused_pad;

   assign f            = vec[F_MSB:F_LSB];
   assign a            = vec[A_MSB:A_LSB];
   assign b            = vec[B_MSB:B_LSB];
   assign exp_y        = vec[Y_MSB:Y_LSB];
   assign exp_zero     = vec[ZERO_BIT];
   assign exp_carry    = vec[CARRY_BIT];
   assign exp_overflow = vec[OVF_BIT];

   assign unused_pad = ^{vec[111], vec[11:9],
                         vec[7:5], vec[3:1]};

endmodule

// File: rtl/alu_vector_player.sv
// Plays ROM test vectors into an ALU and checks its response.
// Counts mismatches and reports each failing index.
module alu_vector_player
   import alu_vector_pkg::*;
#(
   parameter int WIDTH         = 32,
   parameter int NUM_VECTORS   = 32,
   parameter int ADDR_W        = 6,
   parameter int SETTLE_CYCLES = 1,
   localparam int CW = $clog2(NUM_VECTORS + 1)
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   alu_vector_player_if.master bus,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [CW-1:0]     err_count,
   output logic              fail_valid,
   output logic [ADDR_W-1:0] fail_idx
);

   localparam int SW = (SETTLE_CYCLES > 1) ?
                       $clog2(SETTLE_CYCLES) : 1;

   state_t            state;
   state_t            state_nx;
   logic [ADDR_W-1:0] idx;
   logic [VEC_W-1:0]  hold;
   logic [SW-1:0]     cnt;
   logic [2:0]        f_h;
   logic [31:0]       a_h;
   logic [31:0]       b_h;
   logic [31:0]       ey;
   logic              ez;
   logic              ec;
   logic              eo;
   logic              mismatch;
   logic              last;

   alu_vector_unpack u_unpack (
      .vec          (hold),
      .f            (f_h),
      .a            (a_h),
      .b            (b_h),
      .exp_y        (ey),
      .exp_zero     (ez),
      .exp_carry    (ec),
      .exp_overflow (eo)
   );

   // ALU inputs come straight from the holding register
   assign bus.alu_f     = f_h;
   assign bus.alu_a     = WIDTH'(a_h);
   assign bus.alu_b     = WIDTH'(b_h);
   assign bus.vec_addr  = idx;
   assign bus.vec_rd_en = (state == S_FETCH);
   assign busy = (state != S_IDLE) && (state != S_DONE);
   assign done = (state == S_DONE);

   // case equality so X/Z responses count as failures
   assign mismatch = (bus.alu_y        !== WIDTH'(ey)) ||
                     (bus.alu_zero     !== ez) ||
                     (bus.alu_carry    !== ec) ||
                     (bus.alu_overflow !== eo);
   assign last = (idx == ADDR_W'(NUM_VECTORS - 1));

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nx;
   end

   // next-state decode
   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE:   if (start) state_nx = S_FETCH;
         S_FETCH:  state_nx = S_WAIT;
         S_WAIT:   state_nx = S_APPLY;
         S_APPLY:  state_nx = S_SETTLE;
         S_SETTLE: if (cnt == '0) state_nx = S_CHECK;
         S_CHECK:  state_nx = last ? S_DONE : S_FETCH;
         S_DONE:   state_nx = S_IDLE;
         default:  state_nx = S_IDLE;
      endcase
   end

   // index, vector hold, settle count, error tracking
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx        <= '0;
         hold       <= '0;
         cnt        <= '0;
         err_count  <= '0;
         pass       <= 1'b0;
         fail_valid <= 1'b0;
         fail_idx   <= '0;
      end else begin
         fail_valid <= 1'b0;
         unique case (state)
            S_IDLE: if (start) begin
               idx       <= '0;
               err_count <= '0;
               pass      <= 1'b0;
            end
            S_WAIT:   hold <= bus.vec_data;
            S_APPLY:  cnt  <= SW'(SETTLE_CYCLES - 1);
            S_SETTLE: if (cnt != '0) cnt <= cnt - SW'(1);
            S_CHECK: begin
               if (mismatch) begin
                  err_count  <= err_count + CW'(1);
                  fail_valid <= 1'b1;
                  fail_idx   <= idx;
               end
               if (!last) idx <= idx + ADDR_W'(1);
            end
            S_DONE:  pass <= (err_count == '0);
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_vector_player.sv
// Bench for alu_vector_player: ROM + reference ALU models,
// address/fail scoreboards and directed runs on two configs.
module tb_alu_vector_player;
   import alu_vector_pkg::*;

   localparam int N = 32;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic go = 1'b0;
   logic sel = 1'b0;
   logic kill_c = 1'b0;
   logic start_a, start_b;
   always #5 clk = ~clk;

   assign start_a = go & ~sel;
   assign start_b = go & sel;

   alu_vector_player_if #(.WIDTH(32), .ADDR_W(6)) bus_a ();
   alu_vector_player_if #(.WIDTH(32), .ADDR_W(6)) bus_b ();

   logic       busy_a, done_a, pass_a, fv_a;
   logic [5:0] err_a, fi_a;
   logic       busy_b, done_b, pass_b, fv_b;
   logic [0:0] err_b;
   logic [5:0] fi_b;

   alu_vector_player #(
      .WIDTH(32), .NUM_VECTORS(N),
      .ADDR_W(6), .SETTLE_CYCLES(1)
   ) u_a (
      .clk(clk), .rst_n(rst_n), .start(start_a),
      .bus(bus_a), .busy(busy_a), .done(done_a),
      .pass(pass_a), .err_count(err_a),
      .fail_valid(fv_a), .fail_idx(fi_a)
   );

   alu_vector_player #(
      .WIDTH(32), .NUM_VECTORS(1),
      .ADDR_W(6), .SETTLE_CYCLES(3)
   ) u_b (
      .clk(clk), .rst_n(rst_n), .start(start_b),
      .bus(bus_b), .busy(busy_b), .done(done_b),
      .pass(pass_b), .err_count(err_b),
      .fail_valid(fv_b), .fail_idx(fi_b)
   );

   int tests = 0;
   int fails = 0;

   task automatic chk(input string tag,
                      input logic [63:0] obs,
                      input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h",
                tag, obs, exp);
      end
   endtask

   // reference ALU: {y, zero, carry, overflow}
   function automatic logic [34:0] alu_ref(
      input logic [2:0] f, input logic [31:0] a,
      input logic [31:0] b, input logic kc);
      logic [32:0] s;
      logic [31:0] y;
      logic c, v;
      s = '0; y = '0; c = 1'b0; v = 1'b0;
      case (f)
         ALU_AND: y = a & b;
         ALU_OR:  y = a | b;
         ALU_ADD: begin
            s = {1'b0, a} + {1'b0, b};
            y = s[31:0];
            c = s[32] & ~kc;
            v = (a[31] == b[31]) && (y[31] != a[31]);
         end
         ALU_SUB: begin
            s = {1'b0, a} + {1'b0, ~b} + 33'd1;
            y = s[31:0];
            c = s[32];
            v = (a[31] != b[31]) && (y[31] != a[31]);
         end
         ALU_SLT: y = {31'b0, $signed(a) < $signed(b)};
         default: y = '0;
      endcase
      return {y, (y == 32'd0), c, v};
   endfunction

   function automatic logic [111:0] make_vec(
      input logic [2:0] f, input logic [31:0] a,
      input logic [31:0] b);
      logic [34:0] r;
      logic [111:0] v;
      r = alu_ref(f, a, b, 1'b0);
      v = '0;
      v[111] = 1'b1;
      v[10] = 1'b1;
      v[6] = 1'b1;
      v[2] = 1'b1;
      v[110:108] = f;
      v[107:76] = a;
      v[75:44] = b;
      v[43:12] = r[34:3];
      v[8] = r[2];
      v[4] = r[1];
      v[0] = r[0];
      return v;
   endfunction

   logic [111:0] rom_a [N];
   logic [111:0] vec_b;

   // synchronous ROMs
   always @(posedge clk) begin
      if (bus_a.vec_rd_en)
         bus_a.vec_data <= rom_a[bus_a.vec_addr[4:0]];
      if (bus_b.vec_rd_en)
         bus_b.vec_data <= vec_b;
   end

   // combinational ALUs under test
   always_comb begin
      {bus_a.alu_y, bus_a.alu_zero, bus_a.alu_carry,
       bus_a.alu_overflow} = alu_ref(bus_a.alu_f,
         bus_a.alu_a, bus_a.alu_b, kill_c);
      {bus_b.alu_y, bus_b.alu_zero, bus_b.alu_carry,
       bus_b.alu_overflow} = alu_ref(bus_b.alu_f,
         bus_b.alu_a, bus_b.alu_b, 1'b0);
   end

   int exp_addr_q[$];
   int exp_fail_q[$];
   int done_cnt_a = 0;
   int done_cnt_b = 0;
   int fail_cnt_b = 0;

   // scoreboard pops on fetch strobes and fail pulses
   always @(negedge clk) begin
      if (bus_a.vec_rd_en) begin
         chk("addr_q_nonempty", 64'(exp_addr_q.size() > 0), 1);
         if (exp_addr_q.size() > 0)
            chk("vec_addr", bus_a.vec_addr,
                exp_addr_q.pop_front());
      end
      if (fv_a) begin
         chk("fail_q_nonempty", 64'(exp_fail_q.size() > 0), 1);
         if (exp_fail_q.size() > 0)
            chk("fail_idx", fi_a, exp_fail_q.pop_front());
      end
      if (done_a) done_cnt_a++;
      if (done_b) done_cnt_b++;
      if (fv_b)   fail_cnt_b++;
   end

   task automatic push_addrs();
      for (int i = 0; i < N; i++) exp_addr_q.push_back(i);
   endtask

   // start a run and count edges until done is seen
   task automatic run(input logic s, input int restart_at,
                      output int cyc);
      logic d;
      @(negedge clk);
      sel = s;
      go = 1'b1;
      cyc = -1;
      d = 1'b0;
      do begin
         @(posedge clk);
         #1;
         cyc++;
         go = 1'b0;
         if (restart_at >= 0 && bus_a.vec_rd_en &&
             int'(bus_a.vec_addr) == restart_at) go = 1'b1;
         d = s ? done_b : done_a;
      end while (!d && cyc < 2000);
      go = 1'b0;
   endtask

   initial begin
      int cyc;
      int k;
      int dc;
      logic [2:0] codes [5];
      codes[0] = ALU_AND; codes[1] = ALU_OR;
      codes[2] = ALU_ADD; codes[3] = ALU_SUB;
      codes[4] = ALU_SLT;
      for (int i = 0; i < N; i++) begin
         if (i == 5)
            rom_a[i] = make_vec(ALU_ADD, 32'hFFFF_FFFF, 32'd2);
         else if (codes[i % 5] == ALU_ADD)
            rom_a[i] = make_vec(ALU_ADD, 32'(i * 3), 32'(i * 5));
         else
            rom_a[i] = make_vec(codes[i % 5], $urandom, $urandom);
      end
      vec_b = make_vec(ALU_ADD, 32'd1, 32'hFFFF_FFFF);

      #2 rst_n = 1'b0;
      #1;
      chk("rst_busy", busy_a, 0);
      chk("rst_done", done_a, 0);
      chk("rst_pass", pass_a, 0);
      chk("rst_err", err_a, 0);
      chk("rst_rd_en", bus_a.vec_rd_en, 0);
      chk("rst_alu_a", bus_a.alu_a, 0);
      chk("rst_fail_valid", fv_a, 0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;

      // single ADD vector, settle 3
      run(1'b1, -1, cyc);
      chk("b_add_done_cyc", cyc, 7);
      @(posedge clk); #1;
      chk("b_add_pass", pass_b, 1);
      chk("b_add_err", err_b, 0);
      chk("b_add_fails", fail_cnt_b, 0);
      chk("b_add_f_hold", bus_b.alu_f, ALU_ADD);

      // SUB overflow vector, settle 3
      vec_b = make_vec(ALU_SUB, 32'h8000_0000, 32'd1);
      run(1'b1, -1, cyc);
      chk("b_sub_done_cyc", cyc, 7);
      @(posedge clk); #1;
      chk("b_sub_pass", pass_b, 1);
      chk("b_sub_fails", fail_cnt_b, 0);
      chk("b_sub_a_hold", bus_b.alu_a, 32'h8000_0000);
      chk("b_done_pulses", done_cnt_b, 2);

      // full table, good ALU
      push_addrs();
      dc = done_cnt_a;
      run(1'b0, -1, cyc);
      chk("a_done_cyc", cyc, N * 5);
      @(posedge clk); #1;
      chk("a_pass", pass_a, 1);
      chk("a_err", err_a, 0);
      chk("a_busy_after", busy_a, 0);
      chk("a_addr_q_empty", exp_addr_q.size(), 0);
      chk("a_done_pulses", done_cnt_a - dc, 1);

      // carry stuck at 0 on ADD
      kill_c = 1'b1;
      push_addrs();
      exp_fail_q.push_back(5);
      run(1'b0, -1, cyc);
      @(posedge clk); #1;
      chk("kc_err", err_a, 1);
      chk("kc_pass", pass_a, 0);
      chk("kc_fail_q_empty", exp_fail_q.size(), 0);
      chk("kc_addr_q_empty", exp_addr_q.size(), 0);

      // start re-pulsed while busy
      kill_c = 1'b0;
      push_addrs();
      dc = done_cnt_a;
      run(1'b0, 10, cyc);
      chk("rs_done_cyc", cyc, N * 5);
      repeat (3) @(posedge clk);
      #1;
      chk("rs_done_pulses", done_cnt_a - dc, 1);
      chk("rs_busy", busy_a, 0);
      chk("rs_pass", pass_a, 1);
      chk("rs_addr_q_empty", exp_addr_q.size(), 0);

      // reset during vector 7 of a failing run
      kill_c = 1'b1;
      push_addrs();
      exp_fail_q.push_back(5);
      dc = done_cnt_a;
      @(negedge clk);
      sel = 1'b0;
      go = 1'b1;
      @(posedge clk); #1;
      go = 1'b0;
      k = 0;
      while (!(bus_a.vec_rd_en && bus_a.vec_addr == 6'd7)
             && k < 500) begin
         @(posedge clk); #1;
         k++;
      end
      chk("mid_reach_vec7", bus_a.vec_addr, 7);
      chk("mid_err_before", err_a, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_busy", busy_a, 0);
      chk("mid_rd_en", bus_a.vec_rd_en, 0);
      chk("mid_addr", bus_a.vec_addr, 0);
      chk("mid_err", err_a, 0);
      chk("mid_alu_f", bus_a.alu_f, 0);
      chk("mid_alu_b", bus_a.alu_b, 0);
      exp_addr_q.delete();
      exp_fail_q.delete();
      @(negedge clk) rst_n = 1'b1;
      kill_c = 1'b0;
      chk("mid_no_done", done_cnt_a - dc, 0);

      push_addrs();
      run(1'b0, -1, cyc);
      chk("rerun_done_cyc", cyc, N * 5);
      @(posedge clk); #1;
      chk("rerun_err", err_a, 0);
      chk("rerun_pass", pass_a, 1);
      chk("rerun_addr_q_empty", exp_addr_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
